// File: rtl/conv_mac_stream.sv
// conv_mac_stream
// Streaming K-tap convolution engine. Each accepted window of TAPS samples
// is multiplied element-wise by the active coefficient bank. The products
// are summed at full precision and the sum is saturated to ACCW bits.
//
// Parameters:
//   DW     sample / coefficient width
//   TAPS   window size (1..16)
//   ACCW   result width (>= 2*DW)
//   SIGNED 0 = unsigned operands, 1 = two's-complement operands
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   coef_we      write coef_data into shadow slot coef_addr (>= TAPS ignored)
//   coef_addr    shadow slot index
//   coef_data    coefficient value
//   coef_commit  copy the whole shadow bank into the active bank
//   in_valid     window present on in_data
//   in_ready     engine advances this cycle (accepts a window)
//   in_data      sample i at bits [i*DW +: DW]
//   out_valid    result present on out_data
//   out_ready    downstream takes the result this cycle
//   out_data     saturated sum of products
//   out_ovf      out_data was clamped
//
// Pipeline: S1 products -> S2 adder-tree sum -> S3 saturated output.
// All stages share one advance enable, so a stalled output freezes the
// whole pipe and nothing is lost or duplicated.
module conv_mac_stream #(
  parameter int DW     = 8,
  parameter int TAPS   = 9,
  parameter int ACCW   = 32,
  parameter int SIGNED = 0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      coef_we,
  input  logic [((TAPS > 1) ? $clog2(TAPS) : 1)-1:0] coef_addr,
  input  logic [DW-1:0]                             coef_data,
  input  logic                                      coef_commit,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [TAPS*DW-1:0]                        in_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [ACCW-1:0]                           out_data,
  output logic                                      out_ovf
);

  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int LG = (TAPS > 1) ? $clog2(TAPS) : 0;
  localparam int PW = 2 * DW;
  localparam int FW = PW + LG;
  localparam logic [AW:0] TAPS_W = TAPS[AW:0];

  logic [DW-1:0] shadow_reg [TAPS];
  logic [DW-1:0] active_reg [TAPS];

  logic          en;
  logic          s1_valid_reg;
  logic          s2_valid_reg;
  logic [PW-1:0] prod_next [TAPS];
  logic [PW-1:0] prod_reg  [TAPS];
  logic [FW-1:0] prod_ext  [TAPS];
  logic [FW-1:0] sum_next;
  logic [FW-1:0] sum_reg;
  logic [ACCW-1:0] sat_data;
  logic            sat_ovf;

  // Single advance enable for every stage; never depends on in_valid.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Coefficient banks. The commit copies the shadow contents as they were
  // before this edge, so a simultaneous write lands only in the shadow.
  // A window accepted on the commit edge multiplies with the old active bank
  // because S1 samples active_reg before it updates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        shadow_reg[i] <= '0;
        active_reg[i] <= '0;
      end
    end else begin
      if (coef_commit) begin
        for (int i = 0; i < TAPS; i++) begin
          active_reg[i] <= shadow_reg[i];
        end
      end
      if (coef_we && ({1'b0, coef_addr} < TAPS_W)) begin
        shadow_reg[coef_addr] <= coef_data;
      end
    end
  end

  // Multipliers: operands are extended to PW bits first. The low PW bits of
  // the product are identical for signed and unsigned interpretation, so one
  // PW x PW multiply serves both modes once the extension is right.
  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      logic [DW-1:0] smp;
      logic [PW-1:0] smp_x;
      logic [PW-1:0] coef_x;
      assign smp = in_data[gi*DW +: DW];
      if (SIGNED != 0) begin : g_sext
        assign smp_x  = {{DW{smp[DW-1]}}, smp};
        assign coef_x = {{DW{active_reg[gi][DW-1]}}, active_reg[gi]};
      end else begin : g_zext
        assign smp_x  = {{DW{1'b0}}, smp};
        assign coef_x = {{DW{1'b0}}, active_reg[gi]};
      end
      assign prod_next[gi] = smp_x * coef_x;

      // Grow each product to full sum precision before accumulation.
      if (LG == 0) begin : g_noext
        assign prod_ext[gi] = prod_reg[gi];
      end else begin : g_ext
        assign prod_ext[gi] = {{LG{(SIGNED != 0) & prod_reg[gi][PW-1]}}, prod_reg[gi]};
      end
    end
  endgenerate

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < TAPS; i++) begin
      sum_next = sum_next + prod_ext[i];
    end
  end

  // Saturation of the full-precision sum into ACCW bits.
  generate
    if (ACCW >= FW) begin : g_nosat
      if (ACCW == FW) begin : g_eq
        assign sat_data = sum_reg;
      end else begin : g_wide
        assign sat_data = {{(ACCW-FW){(SIGNED != 0) & sum_reg[FW-1]}}, sum_reg};
      end
      assign sat_ovf = 1'b0;
    end else if (SIGNED != 0) begin : g_ssat
      // Fits when every bit from ACCW-1 upward is a copy of the sign.
      logic [FW-ACCW:0] hi;
      assign hi       = sum_reg[FW-1:ACCW-1];
      assign sat_ovf  = !((&hi) || !(|hi));
      assign sat_data = !sat_ovf ? sum_reg[ACCW-1:0]
                      : (sum_reg[FW-1] ? {1'b1, {(ACCW-1){1'b0}}}
                                       : {1'b0, {(ACCW-1){1'b1}}});
    end else begin : g_usat
      assign sat_ovf  = |sum_reg[FW-1:ACCW];
      assign sat_data = sat_ovf ? {ACCW{1'b1}} : sum_reg[ACCW-1:0];
    end
  endgenerate

  // Datapath registers. They carry no reset because the valid bits
  // qualify them.
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      for (int i = 0; i < TAPS; i++) begin
        prod_reg[i] <= prod_next[i];
      end
    end
    if (en && s1_valid_reg) begin
      sum_reg <= sum_next;
    end
  end

  // Valid chain and output register. out_data only loads real results, so
  // it holds its value through bubbles and stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_ovf      <= 1'b0;
    end else if (en) begin
      s1_valid_reg <= in_valid;
      s2_valid_reg <= s1_valid_reg;
      out_valid    <= s2_valid_reg;
      if (s2_valid_reg) begin
        out_data <= sat_data;
        out_ovf  <= sat_ovf;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_stream.sv
// Self-checking bench for conv_mac_stream. Three instances share one
// stimulus: unsigned/32-bit, signed/32-bit and unsigned/16-bit (saturating).
// A reference model keeps the coefficient banks and a queue of expected
// results. Expected values are computed arithmetically from sample x
// coefficient products and then clamped to the output range.
module tb_conv_mac_stream;

  logic        clk;
  logic        rst;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [7:0]  coef_data;
  logic        coef_commit;
  logic        in_valid;
  logic [71:0] in_data;
  logic        out_ready;

  logic        rdy0, vld0, ovf0;
  logic [31:0] dat0;
  logic        rdy1, vld1, ovf1;
  logic [31:0] dat1;
  logic        rdy2, vld2, ovf2;
  logic [15:0] dat2;

  int total = 0;
  int bad   = 0;

  conv_mac_stream #(.DW(8), .TAPS(9), .ACCW(32), .SIGNED(0)) u_uns (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_commit(coef_commit), .in_valid(in_valid),
    .in_ready(rdy0), .in_data(in_data), .out_valid(vld0),
    .out_ready(out_ready), .out_data(dat0), .out_ovf(ovf0));

  conv_mac_stream #(.DW(8), .TAPS(9), .ACCW(32), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_commit(coef_commit), .in_valid(in_valid),
    .in_ready(rdy1), .in_data(in_data), .out_valid(vld1),
    .out_ready(out_ready), .out_data(dat1), .out_ovf(ovf1));

  conv_mac_stream #(.DW(8), .TAPS(9), .ACCW(16), .SIGNED(0)) u_sat (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_commit(coef_commit), .in_valid(in_valid),
    .in_ready(rdy2), .in_data(in_data), .out_valid(vld2),
    .out_ready(out_ready), .out_data(dat2), .out_ovf(ovf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [32:0] r0;   // {ovf, data} unsigned 32-bit
    logic [32:0] r1;   // signed 32-bit
    logic [32:0] r2;   // unsigned 16-bit
    int          age;  // enabled edges seen since acceptance (max 3)
  } ent_t;

  ent_t       q[$];
  logic [7:0] shadow[9];
  logic [7:0] act[9];

  function automatic logic [32:0] model(input logic [71:0] win, input bit sgn, input int accw);
    longint sum, sv, cv, hi, lo;
    logic [7:0] s, c;
    bit ovf;
    sum = 0;
    for (int i = 0; i < 9; i++) begin
      s  = win[i*8 +: 8];
      c  = act[i];
      sv = sgn ? longint'($signed(s)) : longint'(s);
      cv = sgn ? longint'($signed(c)) : longint'(c);
      sum += sv * cv;
    end
    if (sgn) begin
      hi = (longint'(1) << (accw - 1)) - 1;
      lo = -hi - 1;
    end else begin
      hi = (longint'(1) << accw) - 1;
      lo = 0;
    end
    ovf = 1'b0;
    if (sum > hi) begin sum = hi; ovf = 1'b1; end
    if (sum < lo) begin sum = lo; ovf = 1'b1; end
    sum = sum & ((longint'(1) << accw) - 1);
    return {ovf, sum[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model for the
  // coming rising edge, then return 1 time unit after that edge.
  task automatic tick(output bit acc);
    bit   ev, en;
    ent_t e;
    @(negedge clk);
    ev = (q.size() > 0) && (q[0].age >= 3);
    en = !ev || out_ready;
    chk1("rdy_uns", rdy0, en);
    chk1("rdy_sgn", rdy1, en);
    chk1("rdy_sat", rdy2, en);
    chk1("vld_uns", vld0, ev);
    chk1("vld_sgn", vld1, ev);
    chk1("vld_sat", vld2, ev);
    if (ev) begin
      chk("dat_uns", dat0, q[0].r0[31:0]);
      chk1("ovf_uns", ovf0, q[0].r0[32]);
      chk("dat_sgn", dat1, q[0].r1[31:0]);
      chk1("ovf_sgn", ovf1, q[0].r1[32]);
      chk("dat_sat", 32'(dat2), 32'(q[0].r2[15:0]));
      chk1("ovf_sat", ovf2, q[0].r2[32]);
    end
    acc = 1'b0;
    if (!rst) begin
      q.delete();
      for (int i = 0; i < 9; i++) begin
        shadow[i] = 8'd0;
        act[i]    = 8'd0;
      end
    end else begin
      if (en) begin
        if (ev) void'(q.pop_front());
        foreach (q[k]) if (q[k].age < 3) q[k].age++;
        if (in_valid) begin
          e.r0  = model(in_data, 1'b0, 32);
          e.r1  = model(in_data, 1'b1, 32);
          e.r2  = model(in_data, 1'b0, 16);
          e.age = 1;
          q.push_back(e);
          acc = 1'b1;
        end
      end
      if (coef_commit) act = shadow;
      if (coef_we && coef_addr < 4'd9) shadow[coef_addr] = coef_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bit x;
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    tick(x);
    coef_we = 1'b0;
  endtask

  task automatic commit();
    bit x;
    coef_commit = 1'b1;
    tick(x);
    coef_commit = 1'b0;
  endtask

  task automatic load_all(input logic [7:0] d);
    for (int i = 0; i < 9; i++) wr(4'(i), d);
    commit();
  endtask

  task automatic send(input logic [71:0] w);
    bit a;
    int n;
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    a = 1'b0;
    while (!a && n < 40) begin
      tick(a);
      n++;
    end
    chk1("accept", a, 1'b1);
  endtask

  task automatic drain();
    bit x;
    int n;
    in_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      tick(x);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  function automatic logic [71:0] fill(input logic [7:0] v);
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  initial begin
    bit x;
    logic [71:0] w;
    rst = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    coef_commit = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    // Reset state
    tick(x); tick(x);
    rst = 1'b1;
    chk("rst_dat_uns", dat0, 32'd0);
    chk("rst_dat_sat", 32'(dat2), 32'd0);
    chk1("rst_rdy", rdy0, 1'b1);
    chk1("rst_vld", vld0, 1'b0);

    // Unsigned window 1..9 with unit coefficients -> 45, three edges after accept
    load_all(8'd1);
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(i + 1);
    send(w);
    in_valid = 1'b0;
    tick(x); tick(x);
    chk1("lat_vld", vld0, 1'b1);
    chk("sum45", dat0, 32'd45);
    chk1("sum45_ovf", ovf0, 1'b0);
    drain();

    // Coefficients 127, samples -128: signed gives -146304
    load_all(8'd127);
    send(fill(8'h80));
    in_valid = 1'b0;
    tick(x); tick(x);
    chk("neg_const", dat1, 32'hFFFD_C480);
    chk1("neg_ovf", ovf1, 1'b0);
    drain();

    // All 255: 16-bit unsigned clamps; then zero coefficients give 0
    load_all(8'd255);
    send(fill(8'hFF));
    in_valid = 1'b0;
    tick(x); tick(x);
    chk("clamp_dat", 32'(dat2), 32'h0000_FFFF);
    chk1("clamp_ovf", ovf2, 1'b1);
    drain();
    load_all(8'd0);
    send(fill(8'hFF));
    drain();

    // Backpressure: six windows, output stalled four cycles mid-stream
    load_all(8'd1);
    for (int k = 1; k <= 4; k++) send(fill(8'(k)));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = fill(8'd5);
    for (int k = 0; k < 4; k++) tick(x);
    out_ready = 1'b1;
    send(fill(8'd5));
    send(fill(8'd6));
    drain();

    // Coefficient swap: shadow -> 2, slot 9 ignored, commit with window #3;
    // a slot-0 write on the commit edge stays in the shadow only
    for (int i = 0; i < 9; i++) wr(4'(i), 8'd2);
    wr(4'd9, 8'd7);
    in_valid = 1'b1;
    in_data  = fill(8'd1);
    tick(x); tick(x);
    coef_commit = 1'b1; coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'd5;
    tick(x);
    coef_commit = 1'b0; coef_we = 1'b0;
    tick(x); tick(x); tick(x);
    drain();
    commit();
    send(fill(8'd1));
    drain();

    // Randomized traffic with random commits and random backpressure
    for (int n = 0; n < 300; n++) begin
      coef_we     = ($urandom_range(0, 3) == 0);
      coef_addr   = 4'($urandom_range(0, 15));
      coef_data   = 8'($urandom);
      coef_commit = ($urandom_range(0, 7) == 0);
      in_valid    = 1'($urandom_range(0, 1));
      in_data     = 72'({$urandom, $urandom, $urandom});
      out_ready   = ($urandom_range(0, 3) != 0);
      tick(x);
    end
    coef_we = 1'b0; coef_commit = 1'b0; out_ready = 1'b1;
    drain();

    // Reset with two results in flight: dropped, banks cleared
    load_all(8'd3);
    send(fill(8'd1));
    send(fill(8'd2));
    in_valid = 1'b0;
    rst = 1'b0;
    tick(x);
    rst = 1'b1;
    chk("mid_rst_dat_uns", dat0, 32'd0);
    chk("mid_rst_dat_sgn", dat1, 32'd0);
    chk1("mid_rst_rdy", rdy0, 1'b1);
    chk1("mid_rst_vld", vld0, 1'b0);
    tick(x); tick(x); tick(x);
    send(fill(8'd9));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
